// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-RAM arbiter slice.
package dmem_pkg;

    localparam int unsigned ADDR_W          = 20;
    localparam int unsigned DATA_W          = 32;
    localparam int unsigned BE_W            = DATA_W / 8;
    localparam int unsigned RAM_AW          = 17;
    localparam int unsigned DMEM_REGION_BIT = 19;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
    } mem_req_t;

    typedef struct packed {
        logic              rvalid;
        logic              err;
        logic [DATA_W-1:0] rdata;
    } mem_rsp_t;

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_e;

    // Access is rejected outside the data region or on a non-word-aligned address.
    function automatic logic addr_err(input logic [ADDR_W-1:0] addr);
        return !addr[DMEM_REGION_BIT] || (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer names the port that wins a tie.
module rr_arb2
    import dmem_pkg::*;
(
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    port_e ptr_q;
    port_e ptr_d;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ptr_q <= PORT0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // After any grant the tie-break favours the port that just lost.
    always_comb begin
        gnt_o = 2'b00;
        ptr_d = ptr_q;
        if (!reset_i) begin
            if (req_i == 2'b11) begin
                gnt_o = (ptr_q == PORT0) ? 2'b01 : 2'b10;
            end else begin
                gnt_o = req_i;
            end
        end
        if (gnt_o[0]) begin
            ptr_d = PORT1;
        end else if (gnt_o[1]) begin
            ptr_d = PORT0;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data RAM between the LSU (port 0) and the debug/DMA loader (port 1).
module dmem_arbiter
    import dmem_pkg::*;
(
    input  logic              clk,
    input  logic              reset,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [BE_W-1:0]   m0_be,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_err,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic [BE_W-1:0]   m1_be,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_err,

    output logic              ram_en,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic [BE_W-1:0]   ram_be,
    input  logic [DATA_W-1:0] ram_rdata
);

    mem_req_t   req0;
    mem_req_t   req1;
    mem_req_t   sel;
    logic [1:0] gnt;
    logic       any_gnt;
    logic       acc_err;

    logic       resp_valid_q,   resp_valid_d;
    port_e      resp_owner_q,   resp_owner_d;
    logic       resp_err_q,     resp_err_d;
    logic       resp_is_read_q, resp_is_read_d;

    mem_rsp_t   rsp;
    mem_rsp_t   rsp0;
    mem_rsp_t   rsp1;

    assign req0 = {m0_we, m0_addr, m0_wdata, m0_be};
    assign req1 = {m1_we, m1_addr, m1_wdata, m1_be};

    rr_arb2 u_arb (
        .clk_i   (clk),
        .reset_i (reset),
        .req_i   ({m1_req, m0_req}),
        .gnt_o   (gnt)
    );

    assign m0_gnt = gnt[0];
    assign m1_gnt = gnt[1];

    // Decode the winning request and drive the RAM strobe in the grant cycle.
    always_comb begin
        sel       = gnt[1] ? req1 : req0;
        any_gnt   = |gnt;
        acc_err   = addr_err(sel.addr);
        ram_en    = any_gnt && !acc_err;
        ram_we    = ram_en && sel.we;
        ram_addr  = sel.addr[RAM_AW+1:2];
        ram_wdata = sel.wdata;
        ram_be    = sel.we ? sel.be : {BE_W{1'b1}};
    end

    always_comb begin
        resp_valid_d   = any_gnt;
        resp_owner_d   = gnt[1] ? PORT1 : PORT0;
        resp_err_d     = acc_err;
        resp_is_read_d = !sel.we;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            resp_valid_q   <= 1'b0;
            resp_owner_q   <= PORT0;
            resp_err_q     <= 1'b0;
            resp_is_read_q <= 1'b0;
        end else begin
            resp_valid_q   <= resp_valid_d;
            resp_owner_q   <= resp_owner_d;
            resp_err_q     <= resp_err_d;
            resp_is_read_q <= resp_is_read_d;
        end
    end

    // Reset kills an in-flight response in the same cycle; RAM read data only for clean reads.
    always_comb begin
        rsp        = '0;
        rsp.rvalid = resp_valid_q && !reset;
        rsp.err    = rsp.rvalid && resp_err_q;
        rsp.rdata  = (rsp.rvalid && resp_is_read_q && !resp_err_q) ? ram_rdata : '0;
        rsp0       = (resp_owner_q == PORT0) ? rsp : '0;
        rsp1       = (resp_owner_q == PORT1) ? rsp : '0;
    end

    assign m0_rvalid = rsp0.rvalid;
    assign m0_err    = rsp0.err;
    assign m0_rdata  = rsp0.rdata;
    assign m1_rvalid = rsp1.rvalid;
    assign m1_err    = rsp1.err;
    assign m1_rdata  = rsp1.rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed stimulus pushes expectations, a negedge monitor checks them.
module tb_dmem_arbiter;
    import dmem_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              m0_req, m0_we, m1_req, m1_we;
    logic [ADDR_W-1:0] m0_addr, m1_addr;
    logic [DATA_W-1:0] m0_wdata, m1_wdata;
    logic [BE_W-1:0]   m0_be, m1_be;
    logic              m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
    logic [DATA_W-1:0] m0_rdata, m1_rdata;
    logic              ram_en, ram_we;
    logic [RAM_AW-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata, ram_rdata;
    logic [BE_W-1:0]   ram_be;

    logic              ram_init;
    logic              done;
    int                cyc = 0;
    int                checks = 0;
    int                errors = 0;

    localparam logic [ADDR_W-1:0] A96  = 20'h80060;
    localparam logic [ADDR_W-1:0] A100 = 20'h80064;
    localparam logic [ADDR_W-1:0] A102 = 20'h80066;
    localparam logic [ADDR_W-1:0] A200 = 20'h800C8;

    dmem_arbiter dut (
        .clk       (clk),       .reset     (reset),
        .m0_req    (m0_req),    .m0_we     (m0_we),     .m0_addr  (m0_addr),
        .m0_wdata  (m0_wdata),  .m0_be     (m0_be),     .m0_gnt   (m0_gnt),
        .m0_rvalid (m0_rvalid), .m0_rdata  (m0_rdata),  .m0_err   (m0_err),
        .m1_req    (m1_req),    .m1_we     (m1_we),     .m1_addr  (m1_addr),
        .m1_wdata  (m1_wdata),  .m1_be     (m1_be),     .m1_gnt   (m1_gnt),
        .m1_rvalid (m1_rvalid), .m1_rdata  (m1_rdata),  .m1_err   (m1_err),
        .ram_en    (ram_en),    .ram_we    (ram_we),    .ram_addr (ram_addr),
        .ram_wdata (ram_wdata), .ram_be    (ram_be),    .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // One-cycle-latency RAM with byte-enabled writes.
    logic [DATA_W-1:0] mem [0:255];
    always @(posedge clk) begin
        if (ram_init) begin
            mem[24] <= 32'h0000_1234;
            mem[25] <= 32'h0000_0000;
            mem[50] <= 32'hABCD_0050;
        end else if (ram_en) begin
            if (ram_we) begin
                for (int b = 0; b < int'(BE_W); b++)
                    if (ram_be[b]) mem[ram_addr[7:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
            end else begin
                ram_rdata <= mem[ram_addr[7:0]];
            end
        end
    end

    typedef struct {
        logic [1:0]        gnt;
        logic              en;
        logic              we;
        logic [RAM_AW-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
    } cyc_exp_t;

    typedef struct {
        int                due;
        logic              err;
        logic [DATA_W-1:0] rdata;
    } rsp_exp_t;

    cyc_exp_t q_cyc[$];
    rsp_exp_t q_rsp0[$];
    rsp_exp_t q_rsp1[$];

    // ---------------- stimulus ----------------
    task automatic drive(input int p, input logic req, input logic we, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] wdata, input logic [BE_W-1:0] be);
        if (p == 0) begin
            m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_be = be;
        end else begin
            m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_be = be;
        end
    endtask

    task automatic exp_rsp(input int p, input logic err, input logic [DATA_W-1:0] rdata);
        rsp_exp_t e;
        e.due = cyc + 1; e.err = err; e.rdata = rdata;
        if (p == 0) q_rsp0.push_back(e);
        else        q_rsp1.push_back(e);
    endtask

    task automatic step(input logic [1:0] gnt, input logic en, input logic we, input logic [RAM_AW-1:0] addr,
                        input logic [DATA_W-1:0] wdata, input logic [BE_W-1:0] be);
        cyc_exp_t e;
        e.gnt = gnt; e.en = en; e.we = we; e.addr = addr; e.wdata = wdata; e.be = be;
        q_cyc.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(2'b00, 1'b0, 1'b0, '0, '0, '0);
    endtask

    initial begin
        reset = 1'b1; ram_init = 1'b1; done = 1'b0;
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0, '0);
        @(posedge clk); #1;

        // requests during reset are never granted
        drive(0, 1'b1, 1'b0, A96,  32'h1111_1111, 4'h0);
        drive(1, 1'b1, 1'b0, A200, 32'h2222_2222, 4'h0);
        idle(); idle();

        // contention from reset: m0 first, then strict alternation
        reset = 1'b0; ram_init = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i == 5) drive(0, 1'b0, 1'b0, '0, '0, '0);
            if (i % 2 == 0) begin
                exp_rsp(0, 1'b0, 32'h0000_1234);
                step(2'b01, 1'b1, 1'b0, 17'd24, 32'h1111_1111, 4'hF);
            end else begin
                exp_rsp(1, 1'b0, 32'hABCD_0050);
                step(2'b10, 1'b1, 1'b0, 17'd50, 32'h2222_2222, 4'hF);
            end
        end
        drive(1, 1'b0, 1'b0, '0, '0, '0);
        idle();

        // store routing
        drive(0, 1'b1, 1'b1, A100, 32'd25, 4'hF);
        exp_rsp(0, 1'b0, 32'd0);
        step(2'b01, 1'b1, 1'b1, 17'd25, 32'd25, 4'hF);
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        idle();

        // load routing
        drive(0, 1'b1, 1'b0, A96, 32'd0, 4'h0);
        exp_rsp(0, 1'b0, 32'h0000_1234);
        step(2'b01, 1'b1, 1'b0, 17'd24, 32'd0, 4'hF);
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        idle();

        // region error, alignment error, erroneous write
        drive(1, 1'b1, 1'b0, 20'h00060, 32'd0, 4'h0);
        exp_rsp(1, 1'b1, 32'd0);
        step(2'b10, 1'b0, 1'b0, '0, '0, '0);
        drive(1, 1'b1, 1'b0, A102, 32'd0, 4'h0);
        exp_rsp(1, 1'b1, 32'd0);
        step(2'b10, 1'b0, 1'b0, '0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0, '0);
        drive(0, 1'b1, 1'b1, 20'h00064, 32'hFFFF_FFFF, 4'h3);
        exp_rsp(0, 1'b1, 32'd0);
        step(2'b01, 1'b0, 1'b0, '0, '0, '0);

        // sub-word write then read back, back-to-back with no bubble
        drive(0, 1'b1, 1'b1, A100, 32'hDEAD_BEEF, 4'h3);
        exp_rsp(0, 1'b0, 32'd0);
        step(2'b01, 1'b1, 1'b1, 17'd25, 32'hDEAD_BEEF, 4'h3);
        drive(0, 1'b1, 1'b0, A100, 32'd0, 4'h0);
        exp_rsp(0, 1'b0, 32'h0000_BEEF);
        step(2'b01, 1'b1, 1'b0, 17'd25, 32'd0, 4'hF);
        drive(0, 1'b1, 1'b1, A100, 32'd25, 4'hF);
        exp_rsp(0, 1'b0, 32'd0);
        step(2'b01, 1'b1, 1'b1, 17'd25, 32'd25, 4'hF);
        drive(0, 1'b1, 1'b0, A100, 32'd0, 4'h0);
        exp_rsp(0, 1'b0, 32'd25);
        step(2'b01, 1'b1, 1'b0, 17'd25, 32'd0, 4'hF);

        // reset in the cycle after a read grant discards the response
        drive(0, 1'b1, 1'b0, A96, 32'd0, 4'h0);
        step(2'b01, 1'b1, 1'b0, 17'd24, 32'd0, 4'hF);
        reset = 1'b1;
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        idle();
        reset = 1'b0;
        drive(0, 1'b1, 1'b0, A96,  32'd0, 4'h0);
        drive(1, 1'b1, 1'b0, A200, 32'd0, 4'h0);
        exp_rsp(0, 1'b0, 32'h0000_1234);
        step(2'b01, 1'b1, 1'b0, 17'd24, 32'd0, 4'hF);
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        exp_rsp(1, 1'b0, 32'hABCD_0050);
        step(2'b10, 1'b1, 1'b0, 17'd50, 32'd0, 4'hF);
        drive(1, 1'b0, 1'b0, '0, '0, '0);
        idle(); idle();
        done = 1'b1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete (checks=%0d errors=%0d)", checks, errors);
        $fatal(1);
    end

    // ---------------- monitor / scoreboard ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic check_port(input int p, input logic rv, input logic er, input logic [DATA_W-1:0] rd);
        rsp_exp_t e;
        logic     due_now;
        due_now = 1'b0;
        if (p == 0) begin
            if (q_rsp0.size() > 0) due_now = (q_rsp0[0].due == cyc);
        end else begin
            if (q_rsp1.size() > 0) due_now = (q_rsp1[0].due == cyc);
        end
        chk($sformatf("m%0d_rvalid", p), 64'(rv), 64'(due_now));
        if (due_now) begin
            if (p == 0) e = q_rsp0.pop_front();
            else        e = q_rsp1.pop_front();
            if (rv) begin
                chk($sformatf("m%0d_err", p), 64'(er), 64'(e.err));
                chk($sformatf("m%0d_rdata", p), 64'(rd), 64'(e.rdata));
            end
        end
    endtask

    cyc_exp_t ce;
    logic     pend0 = 1'b0;
    logic     pend1 = 1'b0;

    always @(negedge clk) begin
        if (q_cyc.size() > 0) begin
            ce = q_cyc.pop_front();
            chk("gnt", 64'({m1_gnt, m0_gnt}), 64'(ce.gnt));
            chk("ram_en", 64'(ram_en), 64'(ce.en));
            if (ce.en) begin
                chk("ram_we", 64'(ram_we), 64'(ce.we));
                chk("ram_addr", 64'(ram_addr), 64'(ce.addr));
                chk("ram_wdata", 64'(ram_wdata), 64'(ce.wdata));
                chk("ram_be", 64'(ram_be), 64'(ce.be));
            end
        end
        if (reset)
            chk("reset_outputs", 64'({m0_err, m1_err, m0_rdata | m1_rdata}), 64'd0);
        check_port(0, m0_rvalid, m0_err, m0_rdata);
        check_port(1, m1_rvalid, m1_err, m1_rdata);

        // a request must stay up until it is granted
        if (!reset && pend0) chk("m0_req_held", 64'(m0_req), 64'd1);
        if (!reset && pend1) chk("m1_req_held", 64'(m1_req), 64'd1);
        pend0 = m0_req && !m0_gnt && !reset;
        pend1 = m1_req && !m1_gnt && !reset;

        if (done) begin
            chk("m0_rsp_outstanding", 64'(q_rsp0.size()), 64'd0);
            chk("m1_rsp_outstanding", 64'(q_rsp1.size()), 64'd0);
            chk("cyc_exp_outstanding", 64'(q_cyc.size()), 64'd0);
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

endmodule
